// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one system bus between NUM_MASTERS
// masters. It issues a registered one-hot grant and a registered mux select.
// Ownership never moves while a transfer is outstanding (valid=1, ready=0).
// Every hand-off inserts exactly one dead cycle with all grants low.
// Optional feature macro: BUS_ARB_TIMEOUT_EN. When it is defined, an owner
// that holds the bus without transferring for TIMEOUT_CYCLES grant cycles is
// revoked, and timeout_irq pulses for one cycle.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int SEL_W          = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [SEL_W-1:0]       msel,
  input  logic                   valid,
  input  logic                   ready,
  output logic                   bus_busy,
  output logic                   timeout_irq
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_e;

  // Pointer reset value makes master 0 win the first contention.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [SEL_W-1:0]       msel_q, msel_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]       win_idx;
  logic [SEL_W-1:0]       cand;
  logic                   win_found;
  logic                   outstanding;
  logic                   owner_keeps;
  logic                   force_revoke;
  logic                   irq_d;

  // A transfer is pending until the cycle it sees ready.
  assign outstanding = valid && !ready;
  // msel_q holds the owner index while in GRANT.
  assign owner_keeps = breq[msel_q] || outstanding;

  // Round-robin pick: first requester after rr_ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = SEL_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (!win_found && breq[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE/HANDOVER, hold or release in GRANT.
  always_comb begin
    state_d  = state_q;
    bgrant_d = bgrant_q;
    msel_d   = msel_q;
    rr_ptr_d = rr_ptr_q;
    irq_d    = 1'b0;
    case (state_q)
      ST_GRANT: begin
        if (!owner_keeps || force_revoke) begin
          state_d  = ST_HANDOVER;
          bgrant_d = '0;
          rr_ptr_d = msel_q;
          // Only a revoke that overrides a still-holding owner is reported.
          irq_d    = owner_keeps;
        end
      end
      default: begin
        // IDLE and HANDOVER arbitrate identically.
        bgrant_d = '0;
        if (win_found) begin
          state_d           = ST_GRANT;
          bgrant_d[win_idx] = 1'b1;
          msel_d            = win_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, grant, select and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bgrant_q <= '0;
      msel_q   <= '0;
      rr_ptr_q <= PTR_RST;
    end else begin
      state_q  <= state_d;
      bgrant_q <= bgrant_d;
      msel_q   <= msel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_irq_q;

  // A write in flight is never cut off; the revoke waits for valid=0.
  assign force_revoke = (hold_cnt_q >= HOLD_LIMIT) && !valid;

  // Hold counter: clears on GRANT entry and on every completed transfer; saturates at the limit.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_GRANT && state_d == ST_GRANT) begin
      if (valid && ready) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q < HOLD_LIMIT) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end
  end

  // Hold counter and one-cycle revoke pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q    <= '0;
      timeout_irq_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_irq_q <= irq_d;
    end
  end

  assign timeout_irq = timeout_irq_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1) ^ irq_d;
  assign force_revoke       = 1'b0;
  assign timeout_irq        = 1'b0;
`endif

  assign bgrant   = bgrant_q;
  assign msel     = msel_q;
  assign bus_busy = (state_q != ST_IDLE);

endmodule
